// File: rtl/cordic_sched_pkg.sv
// -----------------------------------------------------------------------------
// cordic_sched_pkg
// Shared types and default sizing for the CORDIC vectoring job scheduler.
//   sched_state_e      : scheduler FSM encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   DEF_NUM_REQ/DEF_DW : default requester count and operand/result width
//   DEF_IDW            : default requester-ID width, clog2(DEF_NUM_REQ)
//   DEF_TIMEOUT_CYCLES : default WAIT watchdog limit
// -----------------------------------------------------------------------------
package cordic_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_e;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_DW             = 32;
  localparam int DEF_IDW            = 2;
  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/cordic_vec_scheduler_if.sv
// -----------------------------------------------------------------------------
// cordic_vec_scheduler_if
// Bundles the requester, response and engine channels of the scheduler.
//   req_valid/req_x/req_y/req_ready : per-requester job channel (packed, i*DW)
//   rsp_valid/rsp_ready/rsp_id/rsp_norm/rsp_angle/rsp_err : result channel
//   eng_start/eng_x/eng_y           : engine issue
//   eng_done/eng_norm/eng_angle     : engine completion
// Modports:
//   slave  : the scheduler itself
//   master : requesters, response consumer and engine around it
// -----------------------------------------------------------------------------
interface cordic_vec_scheduler_if #(
  parameter int NUM_REQ = cordic_sched_pkg::DEF_NUM_REQ,
  parameter int DW      = cordic_sched_pkg::DEF_DW,
  parameter int IDW     = cordic_sched_pkg::DEF_IDW
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_x;
  logic [NUM_REQ*DW-1:0] req_y;
  logic [NUM_REQ-1:0]    req_ready;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [DW-1:0]         rsp_norm;
  logic [DW-1:0]         rsp_angle;
  logic                  rsp_err;

  logic                  eng_start;
  logic [DW-1:0]         eng_x;
  logic [DW-1:0]         eng_y;
  logic                  eng_done;
  logic [DW-1:0]         eng_norm;
  logic [DW-1:0]         eng_angle;

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready, eng_done, eng_norm, eng_angle,
    output req_ready, rsp_valid, rsp_id, rsp_norm, rsp_angle, rsp_err,
           eng_start, eng_x, eng_y
  );

  modport master (
    output req_valid, req_x, req_y, rsp_ready, eng_done, eng_norm, eng_angle,
    input  req_ready, rsp_valid, rsp_id, rsp_norm, rsp_angle, rsp_err,
           eng_start, eng_x, eng_y
  );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first asserted request at or after ptr,
// scanning upward and wrapping at NUM_REQ.
//   req       in  NUM_REQ  request vector
//   ptr       in  IDW      highest-priority index
//   grant     out NUM_REQ  one-hot grant (zero when no request)
//   grant_id  out IDW      encoded grant index
//   grant_any out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id,
  output logic               grant_any
);

  always_comb begin
    int cand;
    cand      = 0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // Modulo by subtraction keeps non-power-of-two NUM_REQ correct.
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_any && req[IDW'(cand)]) begin
        grant[IDW'(cand)] = 1'b1;
        grant_id          = IDW'(cand);
        grant_any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_vec_scheduler.sv
// -----------------------------------------------------------------------------
// cordic_vec_scheduler
// Shares one iterative CORDIC vectoring engine between NUM_REQ requesters.
// Jobs are picked round-robin, issued with a one-cycle eng_start, and the
// engine's norm/angle is returned tagged with the requester ID over a
// valid/ready response channel. Operands and results pass through untouched.
//
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : cordic_vec_scheduler_if.slave (requester, response, engine channels)
//
// Build option: define CORDIC_SCHED_TIMEOUT_EN to add a WAIT watchdog that
// aborts after TIMEOUT_CYCLES with rsp_err=1 and zeroed results. Without it
// WAIT lasts until eng_done and rsp_err is constant 0.
// -----------------------------------------------------------------------------
module cordic_vec_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DW             = DEF_DW,
  parameter int IDW            = DEF_IDW,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  cordic_vec_scheduler_if.slave  bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || IDW != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("cordic_vec_scheduler: unsupported NUM_REQ/IDW/TIMEOUT_CYCLES");
  end

  sched_state_e       state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [DW-1:0]      x_q, x_d, y_q, y_d;
  logic [DW-1:0]      norm_q, norm_d, angle_q, angle_d;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_any;
  logic [DW-1:0]      x_sel, y_sel;
  logic               accept;
  logic               rsp_fire;
  logic               done_ok;
  logic               timeout;

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
`endif

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
    if (int'(id) == NUM_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (gnt_oh),
    .grant_id  (gnt_id),
    .grant_any (gnt_any)
  );

  // Every grant is a valid requester, so any grant in IDLE is a handshake.
  assign accept   = (state_q == S_IDLE) && gnt_any;
  assign rsp_fire = (state_q == S_RESP) && bus.rsp_ready;
  assign done_ok  = (state_q == S_WAIT) && bus.eng_done;

`ifdef CORDIC_SCHED_TIMEOUT_EN
  // Counter reads TIMEOUT_CYCLES-1 on the TIMEOUT_CYCLES-th WAIT cycle;
  // a coincident eng_done wins.
  assign timeout = (state_q == S_WAIT) && !bus.eng_done &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        x_sel = bus.req_x[i*DW +: DW];
        y_sel = bus.req_y[i*DW +: DW];
      end
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (bus.eng_done || timeout) state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.req_ready = '0;
    bus.eng_start = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      S_IDLE:  bus.req_ready = gnt_oh;
      S_ISSUE: bus.eng_start = 1'b1;
      S_RESP:  bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Job operands, result capture and pointer update
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    id_d    = id_q;
    norm_d  = norm_q;
    angle_d = angle_q;
    ptr_d   = ptr_q;
    if (accept) begin
      x_d  = x_sel;
      y_d  = y_sel;
      id_d = gnt_id;
    end
    if (done_ok) begin
      norm_d  = bus.eng_norm;
      angle_d = bus.eng_angle;
    end else if (timeout) begin
      norm_d  = '0;
      angle_d = '0;
    end
    if (rsp_fire) ptr_d = next_ptr(id_q);
  end

`ifdef CORDIC_SCHED_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == S_ISSUE)     cnt_d = '0;
    else if (state_q == S_WAIT) cnt_d = cnt_q + 1'b1;
    if (done_ok)      err_d = 1'b0;
    else if (timeout) err_d = 1'b1;
  end
`endif

  // FSM: state register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q   <= '0;
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      norm_q  <= '0;
      angle_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      norm_q  <= norm_d;
      angle_q <= angle_d;
    end
  end

`ifdef CORDIC_SCHED_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.eng_x     = x_q;
  assign bus.eng_y     = y_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_norm  = norm_q;
  assign bus.rsp_angle = angle_q;

endmodule
